// File: rtl/fifo_clase_if.sv
// fifo_clase_if: handshake and status bundle between a producer/consumer and fifo_clase.
//   data_in/push   - write side, driven by the master
//   pop            - read request, driven by the master
//   data_out       - FWFT head word (0 when empty)
//   fifo_empty, fifo_full, almost_full, almost_empty, count, error - status from the FIFO
interface fifo_clase_if #(
    parameter int unsigned WORD_SIZE = 12,
    parameter int unsigned ADDR_SIZE = 3
);
    logic [WORD_SIZE-1:0] data_in;
    logic                 push;
    logic                 pop;
    logic [WORD_SIZE-1:0] data_out;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   count;
    logic                 error;

    modport master (
        output data_in, push, pop,
        input  data_out, fifo_empty, fifo_full, almost_full, almost_empty, count, error
    );

    modport slave (
        input  data_in, push, pop,
        output data_out, fifo_empty, fifo_full, almost_full, almost_empty, count, error
    );
endinterface

// File: rtl/fifo_clase.sv
// fifo_clase: synchronous first-word-fall-through FIFO with almost-full/almost-empty
// thresholds and a sticky overflow/underflow error flag.
//   clk   - rising-edge clock
//   reset - asynchronous, active-low; clears pointers, count and error
//   bus   - fifo_clase_if.slave: data_in/push/pop in; data_out, flags, count, error out
module fifo_clase #(
    parameter int unsigned WORD_SIZE       = 12,
    parameter int unsigned ADDR_SIZE       = 3,
    parameter int unsigned ALMOST_FULL_TH  = 6,
    parameter int unsigned ALMOST_EMPTY_TH = 1
) (
    input  logic         clk,
    input  logic         reset,
    fifo_clase_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_SIZE;
    localparam int unsigned CNT_W = ADDR_SIZE + 1;

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [CNT_W-1:0]     count_q;
    logic                 error_q;

    logic empty_c;
    logic full_c;
    logic push_ok_c;
    logic pop_ok_c;
    logic overflow_c;
    logic underflow_c;

    // Occupancy decode; a pop on a full FIFO frees the slot the push needs.
    assign empty_c     = (count_q == '0);
    assign full_c      = (count_q == CNT_W'(DEPTH));
    assign push_ok_c   = bus.push & (~full_c | bus.pop);
    assign pop_ok_c    = bus.pop & ~empty_c;
    assign overflow_c  = bus.push & full_c & ~bus.pop;
    assign underflow_c = bus.pop & empty_c;

    // Pointers, occupancy and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + ADDR_SIZE'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + ADDR_SIZE'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (overflow_c || underflow_c) begin
                error_q <= 1'b1;
            end
        end
    end

    // Storage; contents survive reset, but nothing is written while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= mem;
        end else if (push_ok_c) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Flags and head word are decoded straight from registered state.
    assign bus.data_out     = empty_c ? '0 : mem[rd_ptr];
    assign bus.fifo_empty   = empty_c;
    assign bus.fifo_full    = full_c;
    assign bus.almost_full  = (count_q >= CNT_W'(ALMOST_FULL_TH));
    assign bus.almost_empty = (count_q <= CNT_W'(ALMOST_EMPTY_TH));
    assign bus.count        = count_q;
    assign bus.error        = error_q;
endmodule
